// File: rtl/router_pkg.sv
// router_pkg: FSM state encoding and default field widths shared by the router selector and its arbiters
package router_pkg;
    typedef enum logic [2:0] {IDLE, CAPTURE, ARB, GRANT, RETIRE} state_t;
    localparam int ADDR_W_DEF = 16;
    localparam int PRI_W_DEF  = 3;
    localparam int DEST_W_DEF = 4;
endpackage

// File: rtl/dest_arbiter.sv
// dest_arbiter: one-hot pick of the lowest-priority-value eligible buffer, ties to lowest index
module dest_arbiter
    import router_pkg::*;
#(
    parameter int NBUF  = 7,
    parameter int PRI_W = PRI_W_DEF
) (
    input  logic [NBUF-1:0]       elig,
    input  logic [NBUF*PRI_W-1:0] pri,
    output logic [NBUF-1:0]       win
);
    logic [PRI_W-1:0] best;
    logic             found;
    // strict less-than keeps the earlier (lower index) buffer on equal priority
    always_comb begin
        win   = '0;
        best  = '1;
        found = 1'b0;
        for (int b = 0; b < NBUF; b++) begin
            if (elig[b] && (!found || pri[b*PRI_W +: PRI_W] < best)) begin
                win    = '0;
                win[b] = 1'b1;
                best   = pri[b*PRI_W +: PRI_W];
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/router_selector.sv
// router_selector: snapshots buffer priorities, arbitrates per destination cell, grants with a watchdog and reports spent buffers
module router_selector
    import router_pkg::*;
#(
    parameter int NBUF    = 7,
    parameter int NCELL   = 16,
    parameter int DEST_W  = DEST_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int PRI_W   = PRI_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NBUF*ADDR_W-1:0]  addr_i,
    input  logic [NBUF*PRI_W-1:0]   pri_i,
    input  logic                    or_mode_i,
    input  logic                    start_i,
    input  logic [NCELL-1:0]        cell_ack_i,
    output logic                    busy_o,
    output logic [NBUF-1:0]         sel_o,
    output logic [NCELL-1:0]        cell_req_o,
    output logic [NBUF-1:0]         spent_o,
    output logic                    spent_valid_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                   state, nxt;
    logic [NBUF*ADDR_W-1:0]   addr_q;
    logic [NBUF*PRI_W-1:0]    pri_q;
    logic                     or_q;
    logic [NBUF-1:0]          sel_q, elig, nsel;
    logic [NCELL-1:0]         acked, dm, acks, done_mask;
    logic [CW-1:0]            cnt;
    logic [DEST_W-1:0]        dest [NBUF];
    logic [NBUF-1:0]          pick [NCELL];

    for (genvar b = 0; b < NBUF; b++) begin : g_buf
        assign elig[b]    = (|pri_q[b*PRI_W +: PRI_W]) && addr_q[b*ADDR_W+DEST_W +: ADDR_W-DEST_W] == '0;
        assign dest[b]    = addr_q[b*ADDR_W +: DEST_W];
        assign spent_o[b] = state == RETIRE && sel_q[b] && acked[dest[b]];
    end

    for (genvar d = 0; d < NCELL; d++) begin : g_cell
        logic [NBUF-1:0] m, w;
        for (genvar b = 0; b < NBUF; b++) begin : g_m
            assign m[b] = elig[b] && dest[b] == DEST_W'(d);
        end
        dest_arbiter #(.NBUF(NBUF), .PRI_W(PRI_W)) u_arb (.elig(m), .pri(pri_q), .win(w));
        assign pick[d] = or_q ? m : w;
        assign dm[d]   = |m;
    end

    assign sel_o         = sel_q;
    assign busy_o        = state != IDLE;
    assign spent_valid_o = state == RETIRE;
    assign cell_req_o    = state == GRANT ? dm & ~acked : '0;
    assign acks          = cell_ack_i & cell_req_o;
    assign done_mask     = (acked | acks) & dm;

    // merge per-destination selections into one buffer mask
    always_comb begin
        nsel = '0;
        for (int d = 0; d < NCELL; d++) nsel |= pick[d];
    end

    // next state: an ack landing on the last watchdog cycle still counts as done
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start_i ? CAPTURE : IDLE;
            CAPTURE: nxt = ARB;
            ARB:     nxt = |nsel ? GRANT : RETIRE;
            GRANT:   nxt = (done_mask == dm || int'(cnt) >= TIMEOUT - 1) ? RETIRE : GRANT;
            RETIRE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // state register, snapshot, selection, ack mask and saturating watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            pri_q  <= '0;
            or_q   <= 1'b0;
            sel_q  <= '0;
            acked  <= '0;
            cnt    <= '0;
        end else begin
            state <= nxt;
            if (state == CAPTURE) begin
                addr_q <= addr_i;
                pri_q  <= pri_i;
                or_q   <= or_mode_i;
            end
            if (state == ARB) begin
                sel_q <= nsel;
                acked <= '0;
                cnt   <= '0;
            end
            if (state == GRANT) begin
                acked <= acked | acks;
                cnt   <= int'(cnt) >= TIMEOUT ? cnt : cnt + 1'b1;
            end
            if (state == RETIRE) begin
                sel_q <= '0;
                acked <= '0;
                cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_router_selector.sv
// tb_router_selector: directed scenario checks of the router selector
module tb_router_selector;
    localparam int NBUF = 7, NCELL = 16, ADDR_W = 16, PRI_W = 3;

    logic                   clk = 0, rst = 1, or_mode_i = 0, start_i = 0;
    logic [NBUF*ADDR_W-1:0] addr_i = '0;
    logic [NBUF*PRI_W-1:0]  pri_i = '0;
    logic [NCELL-1:0]       cell_ack_i = '0;
    logic                   busy_o, spent_valid_o;
    logic [NBUF-1:0]        sel_o, spent_o;
    logic [NCELL-1:0]       cell_req_o;
    int checks = 0, errors = 0;

    router_selector #(.NBUF(NBUF), .NCELL(NCELL), .DEST_W(4), .ADDR_W(ADDR_W), .PRI_W(PRI_W), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .pri_i(pri_i), .or_mode_i(or_mode_i),
        .start_i(start_i), .cell_ack_i(cell_ack_i), .busy_o(busy_o), .sel_o(sel_o),
        .cell_req_o(cell_req_o), .spent_o(spent_o), .spent_valid_o(spent_valid_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bufs;
        addr_i = '0;
        pri_i  = '0;
    endtask

    task automatic set_buf(input int b, input logic [ADDR_W-1:0] a, input logic [PRI_W-1:0] p);
        addr_i[b*ADDR_W +: ADDR_W] = a;
        pri_i[b*PRI_W +: PRI_W]    = p;
    endtask

    task automatic kick;
        start_i = 1;
        tick;
        start_i = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        tick;
        tick;
        checks++; if ({busy_o, spent_valid_o} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {busy_o, spent_valid_o}); end
        checks++; if ({sel_o, spent_o, cell_req_o} !== '0) begin errors++; $display("FAIL reset_vecs: got %h want 0", {sel_o, spent_o, cell_req_o}); end
        rst = 0;
    endtask

    task automatic test_best(input logic om, input logic [NBUF-1:0] exp);
        clear_bufs;
        set_buf(0, 16'h0005, 3'd2);
        set_buf(3, 16'h0005, 3'd1);
        or_mode_i = om;
        kick;
        checks++; if (busy_o !== 1'b1 || sel_o !== '0) begin errors++; $display("FAIL capture om=%0d: got busy=%b sel=%b want busy=1 sel=0", om, busy_o, sel_o); end
        tick;
        clear_bufs;
        or_mode_i = ~om;
        tick;
        checks++; if (sel_o !== exp) begin errors++; $display("FAIL sel om=%0d: got %b want %b", om, sel_o, exp); end
        checks++; if (cell_req_o !== 16'h0020) begin errors++; $display("FAIL req_g0 om=%0d: got %h want 0020", om, cell_req_o); end
        tick;
        checks++; if (cell_req_o !== 16'h0020 || spent_valid_o !== 1'b0) begin errors++; $display("FAIL req_g1 om=%0d: got req=%h sv=%b want 0020/0", om, cell_req_o, spent_valid_o); end
        cell_ack_i = 16'h0024;
        tick;
        cell_ack_i = '0;
        checks++; if (spent_valid_o !== 1'b1 || spent_o !== exp || cell_req_o !== '0) begin errors++; $display("FAIL retire om=%0d: got sv=%b spent=%b req=%h want 1/%b/0", om, spent_valid_o, spent_o, cell_req_o, exp); end
        tick;
        checks++; if (busy_o !== 1'b0 || sel_o !== '0 || spent_valid_o !== 1'b0) begin errors++; $display("FAIL idle om=%0d: got busy=%b sel=%b sv=%b want 0/0/0", om, busy_o, sel_o, spent_valid_o); end
    endtask

    task automatic test_ineligible;
        clear_bufs;
        set_buf(2, 16'h1005, 3'd1);
        or_mode_i = 0;
        kick;
        tick;
        tick;
        checks++; if (spent_valid_o !== 1'b1 || spent_o !== '0 || sel_o !== '0 || cell_req_o !== '0) begin errors++; $display("FAIL inelig: got sv=%b spent=%b sel=%b req=%h want 1/0/0/0", spent_valid_o, spent_o, sel_o, cell_req_o); end
        tick;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL inelig_idle: got busy=%b want 0", busy_o); end
    endtask

    task automatic test_timeout;
        clear_bufs;
        set_buf(1, 16'h0002, 3'd5);
        set_buf(4, 16'h0007, 3'd1);
        or_mode_i = 0;
        kick;
        tick;
        tick;
        checks++; if (sel_o !== 7'b0010010 || cell_req_o !== 16'h0084) begin errors++; $display("FAIL to_g0: got sel=%b req=%h want 0010010/0084", sel_o, cell_req_o); end
        cell_ack_i = 16'h0004;
        tick;
        cell_ack_i = '0;
        checks++; if (cell_req_o !== 16'h0080) begin errors++; $display("FAIL to_g1: got req=%h want 0080", cell_req_o); end
        tick;
        tick;
        checks++; if (busy_o !== 1'b1 || spent_valid_o !== 1'b0 || cell_req_o !== 16'h0080) begin errors++; $display("FAIL to_g3: got busy=%b sv=%b req=%h want 1/0/0080", busy_o, spent_valid_o, cell_req_o); end
        tick;
        checks++; if (spent_valid_o !== 1'b1 || spent_o !== 7'b0000010 || cell_req_o !== '0) begin errors++; $display("FAIL to_retire: got sv=%b spent=%b req=%h want 1/0000010/0", spent_valid_o, spent_o, cell_req_o); end
        tick;
    endtask

    task automatic test_reset_mid_and_tie;
        clear_bufs;
        set_buf(1, 16'h0002, 3'd5);
        or_mode_i = 0;
        kick;
        tick;
        tick;
        tick;
        rst = 1;
        tick;
        checks++; if ({busy_o, spent_valid_o, sel_o, spent_o, cell_req_o} !== '0) begin errors++; $display("FAIL midrst: got %h want 0", {busy_o, spent_valid_o, sel_o, spent_o, cell_req_o}); end
        rst = 0;
        clear_bufs;
        set_buf(5, 16'h0003, 3'd3);
        set_buf(6, 16'h0003, 3'd3);
        kick;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL post_rst_start: got busy=%b want 1", busy_o); end
        tick;
        tick;
        checks++; if (sel_o !== 7'b0100000 || cell_req_o !== 16'h0008) begin errors++; $display("FAIL tie: got sel=%b req=%h want 0100000/0008", sel_o, cell_req_o); end
        start_i = 1;
        cell_ack_i = 16'h0008;
        tick;
        start_i = 0;
        cell_ack_i = '0;
        checks++; if (spent_valid_o !== 1'b1 || spent_o !== 7'b0100000) begin errors++; $display("FAIL tie_retire: got sv=%b spent=%b want 1/0100000", spent_valid_o, spent_o); end
        tick;
        tick;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL start_ignored: got busy=%b want 0", busy_o); end
    endtask

    initial begin
        #1;
        test_reset;
        test_best(1'b0, 7'b0001000);
        test_best(1'b1, 7'b0001001);
        test_ineligible;
        test_timeout;
        test_reset_mid_and_tie;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
